// File: rtl/serial_alu_pkg.sv
// Shared types and constants for the nibble-serial saturating adder.
// NIBBLES and the 16-bit saturation values describe the default 16-bit build.
package serial_alu_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int NIBBLES   = WIDTH_DEF / 4;

    localparam logic [15:0] SAT_POS16 = 16'h7FFF;
    localparam logic [15:0] SAT_NEG16 = 16'h8000;
    localparam logic [3:0]  SAT_POS4  = 4'h7;
    localparam logic [3:0]  SAT_NEG4  = 4'h8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic {
        MODE_ADD16  = 1'b0,
        MODE_PADDSB = 1'b1
    } mode_e;

    // Signed overflow of an add from the operand and sum sign bits.
    function automatic logic sign_ovf(input logic sa, input logic sb, input logic ss);
        return (sa == sb) && (ss != sa);
    endfunction

endpackage

// File: rtl/serial_sat_adder_cla.sv
// 4-bit carry-lookahead adder, reused once per cycle by the serial adder.
module CLA_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;

    assign p = a ^ b;
    assign g = a & b;

    // Fully expanded lookahead: every carry depends only on p, g and cin.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum  = p ^ c[3:0];
    assign cout = c[4];

endmodule

// File: rtl/serial_sat_adder.sv
// Nibble-serial 16-bit add/sub or 4x4-bit PADDSB with signed saturation.
// Saturation is built only when SERIAL_ADD_SAT_EN is defined; otherwise results wrap.
module serial_sat_adder
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             flag_z,
    output logic             flag_v,
    output logic             flag_n
);

    localparam int NIB   = WIDTH / 4;
    localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NIB - 1);

    state_e           state;
    mode_e            mode_q;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             carry;

    logic             cla_cin;
    logic [3:0]       nib_sum;
    logic             nib_cout;
    logic             nib_ov;
    logic [3:0]       nib_out;
    logic [WIDTH-1:0] raw_res;
    logic [WIDTH-1:0] final_res;

    // Operands shift right each cycle, so bit 3 is the current nibble's sign
    // and, on the last nibble, the full-width sign.
    assign cla_cin = (mode_q == MODE_PADDSB) ? 1'b0 : carry;

    CLA_4bit u_cla (
        .a    (op_a[3:0]),
        .b    (op_b[3:0]),
        .cin  (cla_cin),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    assign nib_ov = sign_ovf(op_a[3], op_b[3], nib_sum[3]);

`ifdef SERIAL_ADD_SAT_EN
    localparam logic [WIDTH-1:0] SAT_POS = (WIDTH == 16) ? SAT_POS16 : {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG = (WIDTH == 16) ? SAT_NEG16 : {1'b1, {(WIDTH-1){1'b0}}};

    always_comb begin
        nib_out = nib_sum;
        if (mode_q == MODE_PADDSB && nib_ov)
            nib_out = op_a[3] ? SAT_NEG4 : SAT_POS4;
    end

    assign raw_res = {nib_out, acc[WIDTH-1:4]};

    always_comb begin
        final_res = raw_res;
        if (mode_q == MODE_ADD16 && nib_ov)
            final_res = op_a[3] ? SAT_NEG : SAT_POS;
    end
`else
    assign nib_out   = nib_sum;
    assign raw_res   = {nib_out, acc[WIDTH-1:4]};
    assign final_res = raw_res;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            mode_q <= MODE_ADD16;
            op_a   <= '0;
            op_b   <= '0;
            acc    <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            flag_z <= 1'b0;
            flag_v <= 1'b0;
            flag_n <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        // Subtract is two's complement: invert b, carry-in 1.
                        op_a   <= a;
                        op_b   <= b ^ {WIDTH{sub & ~mode}};
                        carry  <= sub & ~mode;
                        mode_q <= mode_e'(mode);
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= ST_CALC;
                    end else begin
                        state  <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    op_a  <= op_a >> 4;
                    op_b  <= op_b >> 4;
                    carry <= nib_cout;
                    acc   <= raw_res;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= ST_DONE;
                        result <= final_res;
                        flag_z <= (final_res == '0);
                        if (mode_q == MODE_ADD16) begin
                            flag_v <= nib_ov;
                            flag_n <= final_res[WIDTH-1];
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sat_adder.sv
// Directed and random scoreboard bench for serial_sat_adder (follows SERIAL_ADD_SAT_EN).
module tb_serial_sat_adder;

    typedef struct {
        logic [15:0] r;
        logic        z;
        logic        v;
        logic        n;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        sub = 1'b0;
    logic        mode = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        flag_z;
    logic        flag_v;
    logic        flag_n;

    int   errors = 0;
    int   checks = 0;
    logic mv = 1'b0;
    logic mn = 1'b0;
    exp_t sb[$];

    serial_sat_adder #(.WIDTH(16)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .sub    (sub),
        .mode   (mode),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .flag_z (flag_z),
        .flag_v (flag_v),
        .flag_n (flag_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [15:0] ia, input logic [15:0] ib,
                                   input logic isub, input logic imode,
                                   input logic pv, input logic pn);
        exp_t        e;
        logic [15:0] bp;
        logic [15:0] s;
        logic [3:0]  x;
        logic [3:0]  y;
        logic [3:0]  sn;
        logic        ov;
        if (!imode) begin
            bp = isub ? ~ib : ib;
            s  = ia + bp + {15'b0, isub};
            ov = (ia[15] == bp[15]) && (s[15] != ia[15]);
            e.r = s;
`ifdef SERIAL_ADD_SAT_EN
            if (ov) e.r = ia[15] ? 16'h8000 : 16'h7FFF;
`endif
            e.v = ov;
            e.n = e.r[15];
        end else begin
            e.r = '0;
            for (int i = 0; i < 4; i++) begin
                x  = ia[4*i +: 4];
                y  = ib[4*i +: 4];
                sn = x + y;
                ov = (x[3] == y[3]) && (sn[3] != x[3]);
`ifdef SERIAL_ADD_SAT_EN
                if (ov) sn = x[3] ? 4'h8 : 4'h7;
`endif
                e.r[4*i +: 4] = sn;
            end
            e.v = pv;
            e.n = pn;
        end
        e.z = (e.r == 16'h0000);
        return e;
    endfunction

    task automatic push(input logic [15:0] ia, input logic [15:0] ib,
                        input logic isub, input logic imode);
        exp_t e;
        e  = model(ia, ib, isub, imode, mv, mn);
        mv = e.v;
        mn = e.n;
        sb.push_back(e);
    endtask

    // Scoreboard: every done pops the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_done observed=done expected=no_done");
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("result", result, e.r);
                chk("flag_z", {15'b0, flag_z}, {15'b0, e.z});
                chk("flag_v", {15'b0, flag_v}, {15'b0, e.v});
                chk("flag_n", {15'b0, flag_n}, {15'b0, e.n});
            end
        end
    end

    task automatic drive(input logic [15:0] ia, input logic [15:0] ib,
                         input logic isub, input logic imode);
        a = ia; b = ib; sub = isub; mode = imode;
    endtask

    task automatic do_op(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                         input logic isub, input logic imode);
        int n;
        @(negedge clk);
        drive(ia, ib, isub, imode);
        start = 1'b1;
        push(ia, ib, isub, imode);
        @(posedge clk);
        #1 start = 1'b0;
        chk({tag, "_busy"}, {15'b0, busy}, 16'd1);
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!done && n < 12);
        chk({tag, "_latency"}, 16'(n), 16'd4);
    endtask

    task automatic watch_no_done(input string tag, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        chk(tag, {15'b0, seen}, 16'd0);
    endtask

    initial begin
        int n;
        int m;

        // Reset state while rst_n is held low.
        #1;
        chk("rst_busy",   {15'b0, busy}, 16'd0);
        chk("rst_done",   {15'b0, done}, 16'd0);
        chk("rst_result", result, 16'h0000);
        chk("rst_flags",  {13'b0, flag_z, flag_v, flag_n}, 16'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        do_op("add_basic",  16'h1234, 16'h0FF1, 1'b0, 1'b0);
        do_op("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0);
        do_op("sub_zero",   16'h0005, 16'h0005, 1'b1, 1'b0);
        do_op("sub_ovf",    16'h8000, 16'h0001, 1'b1, 1'b0);
        do_op("paddsb_pos", 16'h7171, 16'h1717, 1'b0, 1'b1);
        do_op("paddsb_neg", 16'h8F9A, 16'h8F1C, 1'b0, 1'b1);
        do_op("paddsb_sub", 16'h1234, 16'h1111, 1'b1, 1'b1);
        do_op("add_negneg", 16'hC000, 16'hB000, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++)
            do_op("rnd", 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));

        // Back-to-back: start held through DONE starts the next operation.
        @(negedge clk);
        drive(16'h4000, 16'h4000, 1'b0, 1'b0);
        start = 1'b1;
        push(16'h4000, 16'h4000, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(16'h0003, 16'h0007, 1'b1, 1'b0);
        push(16'h0003, 16'h0007, 1'b1, 1'b0);
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!done && n < 12);
        chk("b2b_first_latency", 16'(n), 16'd4);
        m = 0;
        do begin
            @(posedge clk); #1; m++;
            if (m == 1) begin
                start = 1'b0;
                chk("b2b_busy_again", {15'b0, busy}, 16'd1);
            end
        end while (!done && m < 12);
        chk("b2b_gap", 16'(m), 16'd5);
        watch_no_done("b2b_no_third", 4);

        // Start pulsed during CALC must be ignored.
        @(negedge clk);
        drive(16'h0F0F, 16'h0101, 1'b0, 1'b0);
        start = 1'b1;
        push(16'h0F0F, 16'h0101, 1'b0, 1'b0);
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        drive(16'h1111, 16'h2222, 1'b0, 1'b0);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n = 1;
        do begin
            @(posedge clk); #1; n++;
        end while (!done && n < 12);
        chk("ignore_latency", 16'(n), 16'd4);
        watch_no_done("ignore_no_extra", 6);

        // Reset mid-CALC with the counter at 2.
        @(negedge clk);
        drive(16'h2345, 16'h1111, 1'b0, 1'b0);
        start = 1'b1;
        push(16'h2345, 16'h1111, 1'b0, 1'b0);
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy",   {15'b0, busy}, 16'd0);
        chk("midrst_done",   {15'b0, done}, 16'd0);
        chk("midrst_result", result, 16'h0000);
        chk("midrst_flags",  {13'b0, flag_z, flag_v, flag_n}, 16'd0);
        void'(sb.pop_back());
        mv = 1'b0;
        mn = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        watch_no_done("midrst_no_done", 8);

        do_op("post_rst", 16'h0001, 16'h0002, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        chk("sb_empty", 16'(sb.size()), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
